// File: rtl/tty_iob_if.sv
// KA10 I/O bus, printer and keyboard nets of the console teletype.
// The master side is the CPU/peripheral environment; the slave side is tty_iob.
interface tty_iob_if;
  logic [3:9]  iobus_ios;
  logic        iobus_iob_reset;
  logic        iobus_cono_clear;
  logic        iobus_cono_set;
  logic        iobus_datao_clear;
  logic        iobus_datao_set;
  logic        iobus_iob_datai;
  logic        iobus_iob_coni;
  logic [0:35] iobus_iob_out;
  logic [0:35] iobus_iob_in;
  logic [1:7]  iobus_pi;
  logic [0:7]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [0:7]  rx_data;
  logic        rx_valid;

  modport master (
    output iobus_ios, iobus_iob_reset, iobus_cono_clear, iobus_cono_set,
           iobus_datao_clear, iobus_datao_set, iobus_iob_datai, iobus_iob_coni,
           iobus_iob_out, tx_ready, rx_data, rx_valid,
    input  iobus_iob_in, iobus_pi, tx_data, tx_valid
  );

  modport slave (
    input  iobus_ios, iobus_iob_reset, iobus_cono_clear, iobus_cono_set,
           iobus_datao_clear, iobus_datao_set, iobus_iob_datai, iobus_iob_coni,
           iobus_iob_out, tx_ready, rx_data, rx_valid,
    output iobus_iob_in, iobus_pi, tx_data, tx_valid
  );
endinterface

// File: rtl/tty_iob.sv
// Console TTY on the KA10 I/O bus: CONO/DATAO/CONI/DATAI decode, paced printer output, keyboard input, PI request.
// CONI/DATAI are combinational, PI is one cycle behind its flag; tx_valid holds until tx_ready, then CHAR_CYC cycles to done.
module tty_iob #(
  parameter logic [6:0]  DEV      = 7'o024,
  parameter logic [15:0] CHAR_CYC = 16'd100
) (
  input  logic      clk,
  input  logic      reset,
  tty_iob_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_t;

  state_t      state, state_nxt;
  logic [15:0] timer;
  logic [2:0]  pia;
  logic [7:0]  tto_buf, tti_buf;
  logic        tti_done, tti_ovr, tto_done;
  logic        datai_q;
  logic [1:7]  pi_q, pi_nxt;
  logic [0:35] status;

  logic rst, sel, cono_clr, cono_set, dato_clr, dato_set;
  logic datai_lvl, coni_lvl, datai_fall, tto_busy, char_done;
  logic [0:27] unused_out;

  assign rst        = !reset || bus.iobus_iob_reset;
  assign sel        = (bus.iobus_ios == DEV);
  assign cono_clr   = sel && bus.iobus_cono_clear;
  assign cono_set   = sel && bus.iobus_cono_set;
  assign dato_clr   = sel && bus.iobus_datao_clear;
  assign dato_set   = sel && bus.iobus_datao_set;
  assign datai_lvl  = sel && bus.iobus_iob_datai;
  assign coni_lvl   = sel && bus.iobus_iob_coni;
  assign datai_fall = datai_q && !datai_lvl;
  assign tto_busy   = (state != ST_IDLE);
  assign char_done  = (state == ST_WAIT) && (timer == 16'd0);
  assign unused_out = bus.iobus_iob_out[0:27];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (dato_set)     state_nxt = ST_SEND;
      ST_SEND: if (bus.tx_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (timer == 16'd0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    status         = '0;
    status[28]     = tti_ovr;
    status[29]     = tti_done;
    status[30]     = tto_busy;
    status[31]     = tto_done;
    status[33:35]  = pia;
    bus.tx_valid   = (state == ST_SEND);
    bus.tx_data    = (state == ST_SEND) ? tto_buf : 8'd0;
    bus.iobus_pi   = pi_q;
    bus.iobus_iob_in = '0;
    if (!rst) begin
      if (datai_lvl)     bus.iobus_iob_in[28:35] = tti_buf;
      else if (coni_lvl) bus.iobus_iob_in = status;
    end
  end

  always_comb begin
    pi_nxt = '0;
    for (int i = 1; i <= 7; i++)
      pi_nxt[i] = (pia == 3'(i)) && (tto_done || tti_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pia      <= '0;
      tto_buf  <= '0;
      tti_buf  <= '0;
      tti_done <= 1'b0;
      tti_ovr  <= 1'b0;
      tto_done <= 1'b0;
      datai_q  <= 1'b0;
      timer    <= '0;
      pi_q     <= '0;
    end else begin
      datai_q <= datai_lvl;
      pi_q    <= pi_nxt;

      // Clear and set may arrive together: the set merges into the cleared value.
      if (cono_clr) pia <= 3'd0;
      if (cono_set) pia <= (cono_clr ? 3'd0 : pia) | bus.iobus_iob_out[33:35];
      if (dato_clr) tto_buf <= 8'd0;
      if (dato_set) tto_buf <= (dato_clr ? 8'd0 : tto_buf) | bus.iobus_iob_out[28:35];

      if ((cono_set && bus.iobus_iob_out[31]) || dato_clr) tto_done <= 1'b0;
      if (char_done) tto_done <= 1'b1;

      // A keyboard strobe outranks any same-cycle clear of the input flags.
      if (cono_set && bus.iobus_iob_out[29]) begin
        tti_done <= 1'b0;
        tti_ovr  <= 1'b0;
      end
      if (datai_fall) tti_done <= 1'b0;
      if (bus.rx_valid) begin
        tti_buf  <= bus.rx_data;
        tti_done <= 1'b1;
        if (tti_done) tti_ovr <= 1'b1;
      end

      if (state == ST_SEND && bus.tx_ready) timer <= CHAR_CYC - 16'd1;
      else if (state == ST_WAIT && timer != 16'd0) timer <= timer - 16'd1;
    end
  end

endmodule
